// File: rtl/switch_button_input.sv
// Switch/button front end: 2-flop sync + per-channel debounce, level plus rise/fall strobes.
// Latency DEBOUNCE_CYCLES+2 edges from a held raw change to level/strobe; no backpressure, strobes are one-cycle.
module switch_button_input #(
   parameter int N_INPUTS        = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   localparam int CNT_W          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_INPUTS-1:0] raw_in,
   output logic [N_INPUTS-1:0] level_out,
   output logic [N_INPUTS-1:0] rise_pulse,
   output logic [N_INPUTS-1:0] fall_pulse,
   output logic                any_change
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_INPUTS-1:0] sync1_q, sync1_d;
   logic [N_INPUTS-1:0] sync2_q, sync2_d;
   logic [N_INPUTS-1:0] level_q, level_d;
   logic [N_INPUTS-1:0] rise_q, rise_d;
   logic [N_INPUTS-1:0] fall_q, fall_d;
   logic                any_q, any_d;
   logic [CNT_W-1:0]    cnt_q [N_INPUTS];
   logic [CNT_W-1:0]    cnt_d [N_INPUTS];

   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         cnt_d[i] = cnt_q[i];
         // Any sample matching the accepted level discards the run; no partial credit.
         if (sync2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            level_d[i] = sync2_q[i];
            cnt_d[i]   = '0;
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      any_d = (|rise_d) | (|fall_d);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         any_q   <= 1'b0;
         for (int i = 0; i < N_INPUTS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         any_q   <= any_d;
         for (int i = 0; i < N_INPUTS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign any_change = any_q;

endmodule
